// File: rtl/fcmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fcmp_pkg
//  Purpose  : Shared types and constants for the single-precision comparator.
//             fp32_t     - IEEE-754 single field view {sign, exp, frac}
//             fp_class_t - per-operand classification flags
//  Revision : 1.0 - initial release
// ============================================================================
package fcmp_pkg;

    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;
    localparam int         QNAN_BIT     = 22;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_snan;
    } fp_class_t;

endpackage : fcmp_pkg
`default_nettype wire

// File: rtl/fcmp_classify.sv
`default_nettype none
// ============================================================================
//  Module   : fcmp_classify
//  Purpose  : Combinational classifier for one IEEE-754 single operand.
//  Ports    : op_i  [31:0] operand bits
//             cls_o        {is_zero, is_inf, is_nan, is_snan}
//  Revision : 1.0 - initial release
// ============================================================================
module fcmp_classify
    import fcmp_pkg::*;
(
    input  logic [31:0] op_i,
    output fp_class_t   cls_o
);

    fp32_t w_op;
    logic  w_exp_max;
    logic  w_frac_zero;

    assign w_op        = op_i;
    assign w_exp_max   = (w_op.exp == EXP_ALL_ONES);
    assign w_frac_zero = (w_op.frac == 23'd0);

    // Zero ignores the sign bit so +0 and -0 classify alike.
    assign cls_o.is_zero = (w_op.exp == 8'd0) && w_frac_zero;
    assign cls_o.is_inf  = w_exp_max && w_frac_zero;
    assign cls_o.is_nan  = w_exp_max && !w_frac_zero;
    // A NaN with the quiet bit clear is signalling.
    assign cls_o.is_snan = w_exp_max && !w_frac_zero && !w_op.frac[QNAN_BIT];

endmodule : fcmp_classify
`default_nettype wire

// File: rtl/fcmp_sp.sv
`default_nettype none
// ============================================================================
//  Module   : fcmp_sp
//  Purpose  : IEEE-754 single-precision comparator with one-cycle registered
//             results. Produces mutually exclusive lt/gt/eq flags, plus
//             unordered (NaN), infinity and opa-zero classification.
//  Config   : FCMP_NAN_CLASS_EN - adds snan/qnan outputs.
//  Ports    : clk, rst_n (async, active low)
//             in_valid, opa[31:0], opb[31:0]        - operand strobe/data
//             out_valid                             - registered in_valid
//             unordered, altb, blta, aeqb, inf, zero - registered flags
//             snan, qnan (FCMP_NAN_CLASS_EN only)
//  Revision : 1.0 - initial release
// ============================================================================
module fcmp_sp
    import fcmp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        out_valid,
    output logic        unordered,
    output logic        altb,
    output logic        blta,
    output logic        aeqb,
    output logic        inf,
    output logic        zero
`ifdef FCMP_NAN_CLASS_EN
    ,
    output logic        snan,
    output logic        qnan
`endif
);

    fp_class_t w_cls_a;
    fp_class_t w_cls_b;

    fcmp_classify u_cls_a (
        .op_i  (opa),
        .cls_o (w_cls_a)
    );

    fcmp_classify u_cls_b (
        .op_i  (opb),
        .cls_o (w_cls_b)
    );

    // ------------------------------------------------------------------
    // Compare logic
    // ------------------------------------------------------------------
    logic        w_sign_a;
    logic        w_sign_b;
    logic [30:0] w_mag_a;
    logic [30:0] w_mag_b;
    logic        w_mag_lt;
    logic        w_mag_eq;

    logic unordered_d, altb_d, blta_d, aeqb_d, inf_d, zero_d;

    assign w_sign_a = opa[31];
    assign w_sign_b = opb[31];
    // {exp,frac} is monotonic in magnitude, denormals included.
    assign w_mag_a  = opa[30:0];
    assign w_mag_b  = opb[30:0];
    assign w_mag_lt = (w_mag_a < w_mag_b);
    assign w_mag_eq = (w_mag_a == w_mag_b);

    always_comb begin
        unordered_d = w_cls_a.is_nan | w_cls_b.is_nan;
        inf_d       = w_cls_a.is_inf | w_cls_b.is_inf;
        zero_d      = w_cls_a.is_zero;
        altb_d      = 1'b0;
        blta_d      = 1'b0;
        aeqb_d      = 1'b0;
        if (!unordered_d) begin
            if (w_cls_a.is_zero && w_cls_b.is_zero) begin
                // Signed zeros compare equal.
                aeqb_d = 1'b1;
            end else if (w_sign_a != w_sign_b) begin
                altb_d = w_sign_a;
                blta_d = w_sign_b;
            end else if (w_mag_eq) begin
                aeqb_d = 1'b1;
            end else if (w_sign_a) begin
                // Both negative: larger magnitude is the smaller value.
                altb_d = !w_mag_lt;
                blta_d = w_mag_lt;
            end else begin
                altb_d = w_mag_lt;
                blta_d = !w_mag_lt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic out_valid_q, unordered_q, altb_q, blta_q, aeqb_q, inf_q, zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            unordered_q <= 1'b0;
            altb_q      <= 1'b0;
            blta_q      <= 1'b0;
            aeqb_q      <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                unordered_q <= unordered_d;
                altb_q      <= altb_d;
                blta_q      <= blta_d;
                aeqb_q      <= aeqb_d;
                inf_q       <= inf_d;
                zero_q      <= zero_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign unordered = unordered_q;
    assign altb      = altb_q;
    assign blta      = blta_q;
    assign aeqb      = aeqb_q;
    assign inf       = inf_q;
    assign zero      = zero_q;

`ifdef FCMP_NAN_CLASS_EN
    logic snan_d, qnan_d;
    logic snan_q, qnan_q;

    assign snan_d = w_cls_a.is_snan | w_cls_b.is_snan;
    assign qnan_d = (w_cls_a.is_nan & ~w_cls_a.is_snan) |
                    (w_cls_b.is_nan & ~w_cls_b.is_snan);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snan_q <= 1'b0;
            qnan_q <= 1'b0;
        end else if (in_valid) begin
            snan_q <= snan_d;
            qnan_q <= qnan_d;
        end
    end

    assign snan = snan_q;
    assign qnan = qnan_q;
`else
    // Signalling-NaN class is only consumed by the optional NaN outputs.
    logic w_unused_snan;
    assign w_unused_snan = &{1'b0, w_cls_a.is_snan, w_cls_b.is_snan};
`endif

endmodule : fcmp_sp
`default_nettype wire

// File: tb/tb_fcmp_sp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fcmp_sp
//  Purpose  : Directed self-checking bench for fcmp_sp. Expected flag vectors
//             are hand-computed; flag order is
//             {out_valid, unordered, altb, blta, aeqb, inf, zero}.
//  Config   : FCMP_NAN_CLASS_EN - also checks snan/qnan.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fcmp_sp;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        out_valid, unordered, altb, blta, aeqb, inf, zero;
`ifdef FCMP_NAN_CLASS_EN
    logic        snan, qnan;
`endif

    int n_checks;
    int n_fail;

    fcmp_sp u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .opa       (opa),
        .opb       (opb),
        .out_valid (out_valid),
        .unordered (unordered),
        .altb      (altb),
        .blta      (blta),
        .aeqb      (aeqb),
        .inf       (inf),
        .zero      (zero)
`ifdef FCMP_NAN_CLASS_EN
        ,
        .snan      (snan),
        .qnan      (qnan)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] flags();
        return {out_valid, unordered, altb, blta, aeqb, inf, zero};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one operand pair for a single cycle, then sample after the edge.
    // exp6 = {unordered, altb, blta, aeqb, inf, zero}
    task automatic vec(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] exp6);
        @(negedge clk);
        in_valid = 1'b1;
        opa      = a;
        opb      = b;
        @(posedge clk);
        #1;
        check(tag, {25'd0, flags()}, {25'd0, 1'b1, exp6});
        @(negedge clk);
        in_valid = 1'b0;
        opa      = 32'hDEAD_BEEF;
        opb      = 32'h1234_5678;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        opa      = 32'd0;
        opb      = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {25'd0, flags()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vec("one_lt_two",     32'h3F80_0000, 32'h4000_0000, 6'b010000);
        vec("pz_eq_nz",       32'h0000_0000, 32'h8000_0000, 6'b000101);
        vec("m2_lt_m1",       32'hC000_0000, 32'hBF80_0000, 6'b010000);
        vec("denorm_gt_zero", 32'h0000_0001, 32'h0000_0000, 6'b001000);
        vec("inf_gt_max",     32'h7F80_0000, 32'h7F7F_FFFF, 6'b001010);

        // Hold: flags keep the last vector's result while in_valid is low.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hold", {25'd0, flags()}, {25'd0, 7'b0001010});
        end

        vec("qnan_a",         32'h7FC0_0000, 32'h3F80_0000, 6'b100000);
`ifdef FCMP_NAN_CLASS_EN
        check("qnan_a_cls", {30'd0, snan, qnan}, 32'd1);
`endif
        vec("snan_a",         32'h7F80_0001, 32'h3F80_0000, 6'b100000);
`ifdef FCMP_NAN_CLASS_EN
        check("snan_a_cls", {30'd0, snan, qnan}, 32'd2);
`endif
        vec("qnan_b_neg",     32'h3F80_0000, 32'hFFC0_0000, 6'b100000);
`ifdef FCMP_NAN_CLASS_EN
        check("qnan_b_cls", {30'd0, snan, qnan}, 32'd1);
`endif
        vec("one_eq_one",     32'h3F80_0000, 32'h3F80_0000, 6'b000100);
        vec("ninf_eq_ninf",   32'hFF80_0000, 32'hFF80_0000, 6'b000110);
        vec("m1_lt_p1",       32'hBF80_0000, 32'h3F80_0000, 6'b010000);
        vec("nz_gt_m1",       32'h8000_0000, 32'hBF80_0000, 6'b001001);
        vec("ndenorm_order",  32'h8000_0001, 32'h8000_0002, 6'b001000);
        vec("pinf_gt_ninf",   32'h7F80_0000, 32'hFF80_0000, 6'b001010);
        vec("nz_lt_pdenorm",  32'h8000_0000, 32'h0000_0001, 6'b010001);
        vec("zero_lt_inf",    32'h0000_0000, 32'h7F80_0000, 6'b010011);

        // Asynchronous reset between clock edges clears outputs at once.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {25'd0, flags()}, 32'd0);
`ifdef FCMP_NAN_CLASS_EN
        check("async_reset_nan", {30'd0, snan, qnan}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", {25'd0, flags()}, 32'd0);

        vec("after_reset",    32'h3F80_0000, 32'h4000_0000, 6'b010000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule : tb_fcmp_sp
`default_nettype wire
